// File: rtl/riscv_decode_stage.sv
// Registered RISC-V decode stage: decodes {pc, inst} at enqueue into a DEPTH-entry skid FIFO.
// Define RISCV_DEC_RV32M_EN to decode the RV32M multiply/divide group.

`ifndef RISCV_DECODE_DEFS
`define RISCV_DECODE_DEFS

// ctrl layout (MSB..LSB): pc_update[2] d_write_en d_write[2] d_read[4] alu_src2 alu_op[5] reg_write_en reg_write[2] inst_fmt[3]
`define CTRL_BUS_LEN 21
`define INST_ATTR(pcu, dwe, dw, dr, s2, op, rwe, rw, fmt) {2'(pcu), 1'(dwe), 2'(dw), 4'(dr), 1'(s2), 5'(op), 1'(rwe), 2'(rw), 3'(fmt)}
`define INST_ATTR_NOP {`CTRL_BUS_LEN{1'b0}}

`define INST_FMT_R 3'd0
`define INST_FMT_I 3'd1
`define INST_FMT_S 3'd2
`define INST_FMT_B 3'd3
`define INST_FMT_U 3'd4
`define INST_FMT_J 3'd5

`define ALU_OP_ADD    5'd0
`define ALU_OP_SUB    5'd1
`define ALU_OP_SLL    5'd2
`define ALU_OP_SLT    5'd3
`define ALU_OP_SLTU   5'd4
`define ALU_OP_XOR    5'd5
`define ALU_OP_SRL    5'd6
`define ALU_OP_SRA    5'd7
`define ALU_OP_OR     5'd8
`define ALU_OP_AND    5'd9
`define ALU_OP_EQ     5'd10
`define ALU_OP_NE     5'd11
`define ALU_OP_LT     5'd12
`define ALU_OP_GE     5'd13
`define ALU_OP_LTU    5'd14
`define ALU_OP_GEU    5'd15
`define ALU_OP_MUL    5'd16
`define ALU_OP_MULH   5'd17
`define ALU_OP_MULHSU 5'd18
`define ALU_OP_MULHU  5'd19
`define ALU_OP_DIV    5'd20
`define ALU_OP_DIVU   5'd21
`define ALU_OP_REM    5'd22
`define ALU_OP_REMU   5'd23

`define INST_MASK_R   32'hFE00707F
`define INST_MASK_I   32'h0000707F
`define INST_MASK_SHI 32'hFE00707F
`define INST_MASK_U   32'h0000007F

`define INST_PATT_ADD    32'h00000033
`define INST_PATT_SUB    32'h40000033
`define INST_PATT_SLL    32'h00001033
`define INST_PATT_SLT    32'h00002033
`define INST_PATT_SLTU   32'h00003033
`define INST_PATT_XOR    32'h00004033
`define INST_PATT_SRL    32'h00005033
`define INST_PATT_SRA    32'h40005033
`define INST_PATT_OR     32'h00006033
`define INST_PATT_AND    32'h00007033
`define INST_PATT_ADDI   32'h00000013
`define INST_PATT_SLTI   32'h00002013
`define INST_PATT_SLTIU  32'h00003013
`define INST_PATT_XORI   32'h00004013
`define INST_PATT_ORI    32'h00006013
`define INST_PATT_ANDI   32'h00007013
`define INST_PATT_SLLI   32'h00001013
`define INST_PATT_SRLI   32'h00005013
`define INST_PATT_SRAI   32'h40005013
`define INST_PATT_LB     32'h00000003
`define INST_PATT_LH     32'h00001003
`define INST_PATT_LW     32'h00002003
`define INST_PATT_LBU    32'h00004003
`define INST_PATT_LHU    32'h00005003
`define INST_PATT_SB     32'h00000023
`define INST_PATT_SH     32'h00001023
`define INST_PATT_SW     32'h00002023
`define INST_PATT_BEQ    32'h00000063
`define INST_PATT_BNE    32'h00001063
`define INST_PATT_BLT    32'h00004063
`define INST_PATT_BGE    32'h00005063
`define INST_PATT_BLTU   32'h00006063
`define INST_PATT_BGEU   32'h00007063
`define INST_PATT_JAL    32'h0000006F
`define INST_PATT_JALR   32'h00000067
`define INST_PATT_LUI    32'h00000037
`define INST_PATT_AUIPC  32'h00000017
`define INST_PATT_MUL    32'h02000033
`define INST_PATT_MULH   32'h02001033
`define INST_PATT_MULHSU 32'h02002033
`define INST_PATT_MULHU  32'h02003033
`define INST_PATT_DIV    32'h02004033
`define INST_PATT_DIVU   32'h02005033
`define INST_PATT_REM    32'h02006033
`define INST_PATT_REMU   32'h02007033

`endif

module riscv_decode_stage #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 2,
  parameter int ILL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [`CTRL_BUS_LEN-1:0] out_ctrl,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_imm,
  output logic                     out_illegal,
  output logic [ILL_CNT_W-1:0]     ill_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef RISCV_DEC_RV32M_EN
  localparam int N_M = 8;
`else
  localparam int N_M = 0;
`endif
  localparam int N_INST = 37 + N_M;

  typedef struct packed {
    logic [31:0]              patt;
    logic [31:0]              mask;
    logic [`CTRL_BUS_LEN-1:0] attr;
  } rule_t;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [`CTRL_BUS_LEN-1:0] ctrl;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [XLEN-1:0]          imm;
    logic                     illegal;
  } entry_t;

  // Index 0 has the highest priority.
  localparam rule_t RULES [N_INST] = '{
    {`INST_PATT_ADD,   `INST_MASK_R,   `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_ADD,  1, 0, `INST_FMT_R)},
    {`INST_PATT_SUB,   `INST_MASK_R,   `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_SUB,  1, 0, `INST_FMT_R)},
    {`INST_PATT_SLL,   `INST_MASK_R,   `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_SLL,  1, 0, `INST_FMT_R)},
    {`INST_PATT_SLT,   `INST_MASK_R,   `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_SLT,  1, 0, `INST_FMT_R)},
    {`INST_PATT_SLTU,  `INST_MASK_R,   `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_SLTU, 1, 0, `INST_FMT_R)},
    {`INST_PATT_XOR,   `INST_MASK_R,   `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_XOR,  1, 0, `INST_FMT_R)},
    {`INST_PATT_SRL,   `INST_MASK_R,   `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_SRL,  1, 0, `INST_FMT_R)},
    {`INST_PATT_SRA,   `INST_MASK_R,   `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_SRA,  1, 0, `INST_FMT_R)},
    {`INST_PATT_OR,    `INST_MASK_R,   `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_OR,   1, 0, `INST_FMT_R)},
    {`INST_PATT_AND,   `INST_MASK_R,   `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_AND,  1, 0, `INST_FMT_R)},
    {`INST_PATT_ADDI,  `INST_MASK_I,   `INST_ATTR(0, 0, 0, 0,  1, `ALU_OP_ADD,  1, 0, `INST_FMT_I)},
    {`INST_PATT_SLTI,  `INST_MASK_I,   `INST_ATTR(0, 0, 0, 0,  1, `ALU_OP_SLT,  1, 0, `INST_FMT_I)},
    {`INST_PATT_SLTIU, `INST_MASK_I,   `INST_ATTR(0, 0, 0, 0,  1, `ALU_OP_SLTU, 1, 0, `INST_FMT_I)},
    {`INST_PATT_XORI,  `INST_MASK_I,   `INST_ATTR(0, 0, 0, 0,  1, `ALU_OP_XOR,  1, 0, `INST_FMT_I)},
    {`INST_PATT_ORI,   `INST_MASK_I,   `INST_ATTR(0, 0, 0, 0,  1, `ALU_OP_OR,   1, 0, `INST_FMT_I)},
    {`INST_PATT_ANDI,  `INST_MASK_I,   `INST_ATTR(0, 0, 0, 0,  1, `ALU_OP_AND,  1, 0, `INST_FMT_I)},
    {`INST_PATT_SLLI,  `INST_MASK_SHI, `INST_ATTR(0, 0, 0, 0,  1, `ALU_OP_SLL,  1, 0, `INST_FMT_I)},
    {`INST_PATT_SRLI,  `INST_MASK_SHI, `INST_ATTR(0, 0, 0, 0,  1, `ALU_OP_SRL,  1, 0, `INST_FMT_I)},
    {`INST_PATT_SRAI,  `INST_MASK_SHI, `INST_ATTR(0, 0, 0, 0,  1, `ALU_OP_SRA,  1, 0, `INST_FMT_I)},
    // d_read = {enable, unsigned, size[1:0]}
    {`INST_PATT_LB,    `INST_MASK_I,   `INST_ATTR(0, 0, 0, 8,  1, `ALU_OP_ADD,  1, 1, `INST_FMT_I)},
    {`INST_PATT_LH,    `INST_MASK_I,   `INST_ATTR(0, 0, 0, 9,  1, `ALU_OP_ADD,  1, 1, `INST_FMT_I)},
    {`INST_PATT_LW,    `INST_MASK_I,   `INST_ATTR(0, 0, 0, 10, 1, `ALU_OP_ADD,  1, 1, `INST_FMT_I)},
    {`INST_PATT_LBU,   `INST_MASK_I,   `INST_ATTR(0, 0, 0, 12, 1, `ALU_OP_ADD,  1, 1, `INST_FMT_I)},
    {`INST_PATT_LHU,   `INST_MASK_I,   `INST_ATTR(0, 0, 0, 13, 1, `ALU_OP_ADD,  1, 1, `INST_FMT_I)},
    {`INST_PATT_SB,    `INST_MASK_I,   `INST_ATTR(0, 1, 0, 0,  1, `ALU_OP_ADD,  0, 0, `INST_FMT_S)},
    {`INST_PATT_SH,    `INST_MASK_I,   `INST_ATTR(0, 1, 1, 0,  1, `ALU_OP_ADD,  0, 0, `INST_FMT_S)},
    {`INST_PATT_SW,    `INST_MASK_I,   `INST_ATTR(0, 1, 2, 0,  1, `ALU_OP_ADD,  0, 0, `INST_FMT_S)},
    {`INST_PATT_BEQ,   `INST_MASK_I,   `INST_ATTR(1, 0, 0, 0,  0, `ALU_OP_EQ,   0, 0, `INST_FMT_B)},
    {`INST_PATT_BNE,   `INST_MASK_I,   `INST_ATTR(1, 0, 0, 0,  0, `ALU_OP_NE,   0, 0, `INST_FMT_B)},
    {`INST_PATT_BLT,   `INST_MASK_I,   `INST_ATTR(1, 0, 0, 0,  0, `ALU_OP_LT,   0, 0, `INST_FMT_B)},
    {`INST_PATT_BGE,   `INST_MASK_I,   `INST_ATTR(1, 0, 0, 0,  0, `ALU_OP_GE,   0, 0, `INST_FMT_B)},
    {`INST_PATT_BLTU,  `INST_MASK_I,   `INST_ATTR(1, 0, 0, 0,  0, `ALU_OP_LTU,  0, 0, `INST_FMT_B)},
    {`INST_PATT_BGEU,  `INST_MASK_I,   `INST_ATTR(1, 0, 0, 0,  0, `ALU_OP_GEU,  0, 0, `INST_FMT_B)},
    // reg_write source: 0 alu, 1 memory, 2 pc+4, 3 pc+imm
    {`INST_PATT_JAL,   `INST_MASK_U,   `INST_ATTR(2, 0, 0, 0,  1, `ALU_OP_ADD,  1, 2, `INST_FMT_J)},
    {`INST_PATT_JALR,  `INST_MASK_I,   `INST_ATTR(3, 0, 0, 0,  1, `ALU_OP_ADD,  1, 2, `INST_FMT_I)},
    {`INST_PATT_LUI,   `INST_MASK_U,   `INST_ATTR(0, 0, 0, 0,  1, `ALU_OP_ADD,  1, 0, `INST_FMT_U)},
    {`INST_PATT_AUIPC, `INST_MASK_U,   `INST_ATTR(0, 0, 0, 0,  1, `ALU_OP_ADD,  1, 3, `INST_FMT_U)}
`ifdef RISCV_DEC_RV32M_EN
    ,
    {`INST_PATT_MUL,    `INST_MASK_R,  `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_MUL,    1, 0, `INST_FMT_R)},
    {`INST_PATT_MULH,   `INST_MASK_R,  `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_MULH,   1, 0, `INST_FMT_R)},
    {`INST_PATT_MULHSU, `INST_MASK_R,  `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_MULHSU, 1, 0, `INST_FMT_R)},
    {`INST_PATT_MULHU,  `INST_MASK_R,  `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_MULHU,  1, 0, `INST_FMT_R)},
    {`INST_PATT_DIV,    `INST_MASK_R,  `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_DIV,    1, 0, `INST_FMT_R)},
    {`INST_PATT_DIVU,   `INST_MASK_R,  `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_DIVU,   1, 0, `INST_FMT_R)},
    {`INST_PATT_REM,    `INST_MASK_R,  `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_REM,    1, 0, `INST_FMT_R)},
    {`INST_PATT_REMU,   `INST_MASK_R,  `INST_ATTR(0, 0, 0, 0,  0, `ALU_OP_REMU,   1, 0, `INST_FMT_R)}
`endif
  };

  logic                     hit;
  logic [`CTRL_BUS_LEN-1:0] dec_ctrl;
  logic [2:0]               dec_fmt;
  logic signed [31:0]       imm32;
  entry_t                   ent_d;

  always_comb begin
    hit      = 1'b0;
    dec_ctrl = `INST_ATTR_NOP;
    // Scan from the lowest priority up so the earliest matching rule wins.
    for (int i = N_INST - 1; i >= 0; i--) begin
      if ((in_inst & RULES[i].mask) == RULES[i].patt) begin
        hit      = 1'b1;
        dec_ctrl = RULES[i].attr;
      end
    end
    if (in_inst[1:0] != 2'b11) begin
      hit      = 1'b0;
      dec_ctrl = `INST_ATTR_NOP;
    end
    dec_fmt = dec_ctrl[2:0];

    ent_d         = '0;
    ent_d.pc      = in_pc;
    ent_d.ctrl    = dec_ctrl;
    ent_d.illegal = ~hit;
    ent_d.rs1     = in_inst[19:15];
    ent_d.rs2     = in_inst[24:20];
    ent_d.rd      = in_inst[11:7];
    imm32         = '0;
    case (dec_fmt)
      `INST_FMT_I: begin
        ent_d.rs2 = '0;
        if (in_inst[6:0] == 7'b0010011 && in_inst[13:12] == 2'b01)
          imm32 = {27'b0, in_inst[24:20]};
        else
          imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      `INST_FMT_S: begin
        ent_d.rd = '0;
        imm32    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      `INST_FMT_B: begin
        ent_d.rd = '0;
        imm32    = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      `INST_FMT_U: begin
        ent_d.rs1 = '0;
        ent_d.rs2 = '0;
        imm32     = {in_inst[31:12], 12'b0};
      end
      `INST_FMT_J: begin
        ent_d.rs1 = '0;
        ent_d.rs2 = '0;
        imm32     = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      default: ;
    endcase
    ent_d.imm = XLEN'(imm32);
    if (!hit) begin
      ent_d.rs1 = '0;
      ent_d.rs2 = '0;
      ent_d.rd  = '0;
      ent_d.imm = '0;
    end
  end

  entry_t               mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic                 push, pop;
  entry_t               head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready depends only on occupancy, never on out_ready.
  assign in_ready  = rst_n & (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    if (push && ent_d.illegal && ill_cnt_q != '1)
      ill_cnt_d = ill_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ill_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ent_d;
  end

  assign head    = mem_q[rd_ptr_q];
  assign ill_cnt = ill_cnt_q;

  always_comb begin
    out_pc      = '0;
    out_ctrl    = `INST_ATTR_NOP;
    out_rs1     = '0;
    out_rs2     = '0;
    out_rd      = '0;
    out_imm     = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_pc      = head.pc;
      out_ctrl    = head.ctrl;
      out_rs1     = head.rs1;
      out_rs2     = head.rs2;
      out_rd      = head.rd;
      out_imm     = head.imm;
      out_illegal = head.illegal;
    end
  end

endmodule
